// File: rtl/exc_ctrl_pkg.sv
// Shared constants for the commit-stage exception/interrupt controller.
package exc_ctrl_pkg;

  localparam int unsigned XLEN     = 32;
  localparam int unsigned EXC_W    = 7;
  localparam int unsigned EXCODE_W = 5;
  localparam int unsigned STATE_W  = 2;
  localparam int unsigned BADV_W   = 2;

  // CP0 Cause.ExcCode values
  localparam logic [EXCODE_W-1:0] EXC_INT  = 5'd0;
  localparam logic [EXCODE_W-1:0] EXC_ADEL = 5'd4;
  localparam logic [EXCODE_W-1:0] EXC_ADES = 5'd5;
  localparam logic [EXCODE_W-1:0] EXC_SYS  = 5'd8;
  localparam logic [EXCODE_W-1:0] EXC_BP   = 5'd9;
  localparam logic [EXCODE_W-1:0] EXC_RI   = 5'd10;
  localparam logic [EXCODE_W-1:0] EXC_OV   = 5'd12;

  // Bit positions inside mem_exc
  localparam int unsigned EXB_ADEL_IF = 0;
  localparam int unsigned EXB_RI      = 1;
  localparam int unsigned EXB_OV      = 2;
  localparam int unsigned EXB_SYS     = 3;
  localparam int unsigned EXB_BP      = 4;
  localparam int unsigned EXB_ADEL_D  = 5;
  localparam int unsigned EXB_ADES    = 6;

  // CP0 Status bit positions
  localparam int unsigned STATUS_BEV = 22;
  localparam int unsigned STATUS_EXL = 1;

  // Controller state encoding
  localparam logic [STATE_W-1:0] ST_IDLE     = 2'd0;
  localparam logic [STATE_W-1:0] ST_FLUSH    = 2'd1;
  localparam logic [STATE_W-1:0] ST_REDIRECT = 2'd2;

  // BadVAddr source select
  localparam logic [BADV_W-1:0] BADV_NONE = 2'd0;
  localparam logic [BADV_W-1:0] BADV_PC   = 2'd1;
  localparam logic [BADV_W-1:0] BADV_DATA = 2'd2;

endpackage

// File: rtl/exc_prio_enc.sv
// Priority encoder: picks the winning event among interrupt, exception flags and ERET.
module exc_prio_enc
  import exc_ctrl_pkg::*;
(
  input  logic [EXC_W-1:0]    exc,
  input  logic                int_pending,
  input  logic                eret,
  output logic                event_c,
  output logic [EXCODE_W-1:0] excode_c,
  output logic                eret_sel_c,
  output logic [BADV_W-1:0]   badv_sel_c
);

  // Fixed priority: Int > AdEL-fetch > RI > Ov > Sys > Bp > AdEL-data > AdES > ERET
  always_comb begin
    event_c    = int_pending | (|exc) | eret;
    excode_c   = '0;
    eret_sel_c = 1'b0;
    badv_sel_c = BADV_NONE;
    if (int_pending) begin
      excode_c = EXC_INT;
    end else if (exc[EXB_ADEL_IF]) begin
      excode_c   = EXC_ADEL;
      badv_sel_c = BADV_PC;
    end else if (exc[EXB_RI]) begin
      excode_c = EXC_RI;
    end else if (exc[EXB_OV]) begin
      excode_c = EXC_OV;
    end else if (exc[EXB_SYS]) begin
      excode_c = EXC_SYS;
    end else if (exc[EXB_BP]) begin
      excode_c = EXC_BP;
    end else if (exc[EXB_ADEL_D]) begin
      excode_c   = EXC_ADEL;
      badv_sel_c = BADV_DATA;
    end else if (exc[EXB_ADES]) begin
      excode_c   = EXC_ADES;
      badv_sel_c = BADV_DATA;
    end else if (eret) begin
      eret_sel_c = 1'b1;
    end
  end

endmodule

// File: rtl/exc_ctrl.sv
// Commit-stage exception/interrupt controller: signals CP0, flushes, then redirects fetch.
module exc_ctrl
  import exc_ctrl_pkg::*;
#(
  parameter logic [31:0] VEC_BEV1     = 32'hBFC0_0380,
  parameter logic [31:0] VEC_BEV0     = 32'h8000_0180,
  parameter int unsigned FLUSH_CYCLES = 1
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                mem_valid,
  input  logic [XLEN-1:0]     mem_pc,
  input  logic                mem_bd,
  input  logic [EXC_W-1:0]    mem_exc,
  input  logic [XLEN-1:0]     mem_data_addr,
  input  logic                mem_eret,
  input  logic                ext_int_response,
  input  logic [XLEN-1:0]     cp0_status,
  input  logic [XLEN-1:0]     cp0_epc,
  output logic                exc_valid,
  output logic [EXCODE_W-1:0] exc_excode,
  output logic                exc_bd,
  output logic [XLEN-1:0]     exc_epc,
  output logic [XLEN-1:0]     exc_badvaddr,
  output logic                exc_eret,
  output logic                flush,
  output logic                redirect_valid,
  output logic [XLEN-1:0]     redirect_pc,
  input  logic                redirect_ready,
  output logic                busy
);

  localparam int unsigned CNT_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(FLUSH_CYCLES - 1);

  logic [STATE_W-1:0]  state;
  logic [STATE_W-1:0]  state_nxt;
  logic [CNT_W-1:0]    flush_cnt;
  logic                int_pending;

  logic                enc_event_c;
  logic [EXCODE_W-1:0] enc_excode_c;
  logic                enc_eret_sel_c;
  logic [BADV_W-1:0]   enc_badv_sel_c;
  logic                take_c;
  logic                int_taken_c;
  logic [XLEN-1:0]     vec_c;

  // Status bits other than BEV do not affect sequencing; EXL handling lives in CP0.
  logic                unused_status_c;
  assign unused_status_c = ^{cp0_status[XLEN-1:STATUS_BEV+1], cp0_status[STATUS_BEV-1:0]};

  exc_prio_enc u_prio (
    .exc         (mem_exc),
    .int_pending (int_pending),
    .eret        (mem_eret),
    .event_c     (enc_event_c),
    .excode_c    (enc_excode_c),
    .eret_sel_c  (enc_eret_sel_c),
    .badv_sel_c  (enc_badv_sel_c)
  );

  // An event is accepted only from IDLE with a committing instruction.
  assign take_c      = (state == ST_IDLE) && mem_valid && enc_event_c;
  assign int_taken_c = take_c && int_pending;
  assign vec_c       = cp0_status[STATUS_BEV] ? VEC_BEV1 : VEC_BEV0;
  assign busy        = (state != ST_IDLE);

  // State register
  always_ff @(posedge clk) begin
    if (!resetn) state <= ST_IDLE;
    else         state <= state_nxt;
  end

  // Next state and combinational CP0/flush outputs
  always_comb begin
    state_nxt    = state;
    exc_valid    = 1'b0;
    exc_excode   = '0;
    exc_bd       = 1'b0;
    exc_epc      = '0;
    exc_badvaddr = '0;
    exc_eret     = 1'b0;
    flush        = 1'b0;
    case (state)
      ST_IDLE: begin
        if (take_c) begin
          state_nxt = ST_FLUSH;
          exc_valid = 1'b1;
          flush     = 1'b1;
          exc_eret  = enc_eret_sel_c;
          if (!enc_eret_sel_c) begin
            exc_excode = enc_excode_c;
            exc_bd     = mem_bd;
            exc_epc    = mem_bd ? (mem_pc - 32'd4) : mem_pc;
          end
          case (enc_badv_sel_c)
            BADV_PC:   exc_badvaddr = mem_pc;
            BADV_DATA: exc_badvaddr = mem_data_addr;
            default:   exc_badvaddr = '0;
          endcase
        end
      end
      ST_FLUSH: begin
        flush = 1'b1;
        if (flush_cnt == '0) state_nxt = ST_REDIRECT;
      end
      ST_REDIRECT: begin
        if (redirect_ready) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Interrupt sampling, flush counter and redirect handshake registers
  always_ff @(posedge clk) begin
    if (!resetn) begin
      int_pending    <= 1'b0;
      flush_cnt      <= '0;
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
    end else begin
      int_pending <= int_taken_c ? 1'b0 : ext_int_response;
      case (state)
        ST_IDLE: begin
          if (take_c) begin
            flush_cnt   <= CNT_INIT;
            redirect_pc <= enc_eret_sel_c ? cp0_epc : vec_c;
          end
        end
        ST_FLUSH: begin
          if (flush_cnt == '0) redirect_valid <= 1'b1;
          else                 flush_cnt      <= flush_cnt - CNT_W'(1);
        end
        ST_REDIRECT: begin
          if (redirect_ready) redirect_valid <= 1'b0;
        end
        default: redirect_valid <= 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_exc_ctrl.sv
// Directed self-checking bench for exc_ctrl.
module tb_exc_ctrl;

  logic        clk;
  logic        resetn;
  logic        mem_valid;
  logic [31:0] mem_pc;
  logic        mem_bd;
  logic [6:0]  mem_exc;
  logic [31:0] mem_data_addr;
  logic        mem_eret;
  logic        ext_int_response;
  logic [31:0] cp0_status;
  logic [31:0] cp0_epc;
  logic        exc_valid;
  logic [4:0]  exc_excode;
  logic        exc_bd;
  logic [31:0] exc_epc;
  logic [31:0] exc_badvaddr;
  logic        exc_eret;
  logic        flush;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        redirect_ready;
  logic        busy;

  int n_cmp;
  int n_err;

  localparam logic [31:0] BEV1 = 32'h0040_0000;

  exc_ctrl dut (
    .clk              (clk),
    .resetn           (resetn),
    .mem_valid        (mem_valid),
    .mem_pc           (mem_pc),
    .mem_bd           (mem_bd),
    .mem_exc          (mem_exc),
    .mem_data_addr    (mem_data_addr),
    .mem_eret         (mem_eret),
    .ext_int_response (ext_int_response),
    .cp0_status       (cp0_status),
    .cp0_epc          (cp0_epc),
    .exc_valid        (exc_valid),
    .exc_excode       (exc_excode),
    .exc_bd           (exc_bd),
    .exc_epc          (exc_epc),
    .exc_badvaddr     (exc_badvaddr),
    .exc_eret         (exc_eret),
    .flush            (flush),
    .redirect_valid   (redirect_valid),
    .redirect_pc      (redirect_pc),
    .redirect_ready   (redirect_ready),
    .busy             (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    mem_valid     = 1'b0;
    mem_pc        = '0;
    mem_bd        = 1'b0;
    mem_exc       = '0;
    mem_data_addr = '0;
    mem_eret      = 1'b0;
  endtask

  task automatic apply(input logic [31:0] pc, input logic bd, input logic [6:0] exc,
                       input logic [31:0] daddr, input logic eret);
    mem_valid     = 1'b1;
    mem_pc        = pc;
    mem_bd        = bd;
    mem_exc       = exc;
    mem_data_addr = daddr;
    mem_eret      = eret;
  endtask

  // Checks the event-cycle CP0 outputs at the negedge
  task automatic expect_evt(input string tag, input logic [4:0] code, input logic bd,
                            input logic [31:0] epc, input logic [31:0] badv, input logic eret);
    @(negedge clk);
    chk({tag, ".valid"}, 32'(exc_valid), 32'd1);
    chk({tag, ".code"},  32'(exc_excode), 32'(code));
    chk({tag, ".bd"},    32'(exc_bd), 32'(bd));
    chk({tag, ".epc"},   exc_epc, epc);
    chk({tag, ".badv"},  exc_badvaddr, badv);
    chk({tag, ".eret"},  32'(exc_eret), 32'(eret));
    chk({tag, ".flush"}, 32'(flush), 32'd1);
    chk({tag, ".busy"},  32'(busy), 32'd0);
  endtask

  // From the event-cycle negedge: FLUSH, REDIRECT with expected PC, handshake, back to IDLE
  task automatic drain(input string tag, input logic [31:0] rpc);
    cycle();
    idle_inputs();
    @(negedge clk);
    chk({tag, ".fl_flush"}, 32'(flush), 32'd1);
    chk({tag, ".fl_busy"},  32'(busy), 32'd1);
    chk({tag, ".fl_rv"},    32'(redirect_valid), 32'd0);
    chk({tag, ".fl_exc"},   32'(exc_valid), 32'd0);
    cycle();
    @(negedge clk);
    chk({tag, ".rd_rv"},    32'(redirect_valid), 32'd1);
    chk({tag, ".rd_pc"},    redirect_pc, rpc);
    chk({tag, ".rd_flush"}, 32'(flush), 32'd0);
    redirect_ready = 1'b1;
    cycle();
    redirect_ready = 1'b0;
    @(negedge clk);
    chk({tag, ".done_busy"}, 32'(busy), 32'd0);
    chk({tag, ".done_rv"},   32'(redirect_valid), 32'd0);
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    resetn           = 1'b0;
    ext_int_response = 1'b0;
    cp0_status       = '0;
    cp0_epc          = '0;
    redirect_ready   = 1'b0;
    idle_inputs();
    cycle();
    cycle();
    @(negedge clk);
    chk("rst.busy",  32'(busy), 32'd0);
    chk("rst.rv",    32'(redirect_valid), 32'd0);
    chk("rst.rpc",   redirect_pc, 32'd0);
    chk("rst.flush", 32'(flush), 32'd0);
    chk("rst.exc",   32'(exc_valid), 32'd0);
    chk("rst.intp",  32'(dut.int_pending), 32'd0);
    cycle();
    resetn = 1'b1;
    cycle();

    // Overflow, BEV=0
    apply(32'h8000_1000, 1'b0, 7'b000_0100, 32'h0, 1'b0);
    expect_evt("ov", 5'd12, 1'b0, 32'h8000_1000, 32'h0, 1'b0);
    drain("ov", 32'h8000_0180);

    // AdES in delay slot, BEV=1
    cycle();
    cp0_status = BEV1;
    apply(32'h8000_2004, 1'b1, 7'b100_0000, 32'h0000_1003, 1'b0);
    expect_evt("ades", 5'd5, 1'b1, 32'h8000_2000, 32'h0000_1003, 1'b0);
    drain("ades", 32'hBFC0_0380);
    cp0_status = '0;

    // Invalid commit carries flags but must not raise an event
    apply(32'h8000_3000, 1'b0, 7'b000_0100, 32'h0, 1'b0);
    mem_valid = 1'b0;
    @(negedge clk);
    chk("nv.exc",   32'(exc_valid), 32'd0);
    chk("nv.flush", 32'(flush), 32'd0);
    cycle();
    @(negedge clk);
    chk("nv.busy",  32'(busy), 32'd0);

    // redirect_ready while IDLE is ignored
    redirect_ready = 1'b1;
    cycle();
    redirect_ready = 1'b0;
    @(negedge clk);
    chk("rdyidle.busy", 32'(busy), 32'd0);
    chk("rdyidle.rv",   32'(redirect_valid), 32'd0);

    // AdEL-fetch beats RI and AdEL-data; badvaddr is the PC
    cycle();
    apply(32'h8000_4001, 1'b0, 7'b010_0011, 32'h0000_5555, 1'b0);
    expect_evt("adelif", 5'd4, 1'b0, 32'h8000_4001, 32'h8000_4001, 1'b0);
    drain("adelif", 32'h8000_0180);

    // Ov beats Sys even though Sys has the smaller code
    cycle();
    apply(32'h8000_5000, 1'b0, 7'b000_1100, 32'h0, 1'b0);
    expect_evt("ovsys", 5'd12, 1'b0, 32'h8000_5000, 32'h0, 1'b0);
    drain("ovsys", 32'h8000_0180);

    // Bp in delay slot at PC 0: EPC wraps
    cycle();
    apply(32'h0000_0000, 1'b1, 7'b001_0000, 32'h0, 1'b0);
    expect_evt("bpwrap", 5'd9, 1'b1, 32'hFFFF_FFFC, 32'h0, 1'b0);
    drain("bpwrap", 32'h8000_0180);

    // AdEL-data alone: badvaddr is the data address
    cycle();
    apply(32'h8000_6000, 1'b0, 7'b010_0000, 32'h0000_7002, 1'b0);
    expect_evt("adeld", 5'd4, 1'b0, 32'h8000_6000, 32'h0000_7002, 1'b0);
    drain("adeld", 32'h8000_0180);

    // Interrupt seen one cycle before a Sys commit: Int wins
    cycle();
    ext_int_response = 1'b1;
    cycle();
    apply(32'h8000_8000, 1'b0, 7'b000_1000, 32'h0, 1'b0);
    expect_evt("int", 5'd0, 1'b0, 32'h8000_8000, 32'h0, 1'b0);
    chk("int.pend_set", 32'(dut.int_pending), 32'd1);
    cycle();
    idle_inputs();
    @(negedge clk);
    chk("int.pend_clr", 32'(dut.int_pending), 32'd0);
    chk("int.fl_flush", 32'(flush), 32'd1);
    ext_int_response = 1'b0;
    cycle();
    @(negedge clk);
    chk("int.rd_rv", 32'(redirect_valid), 32'd1);
    chk("int.rd_pc", redirect_pc, 32'h8000_0180);
    redirect_ready = 1'b1;
    cycle();
    redirect_ready = 1'b0;
    @(negedge clk);
    chk("int.done_busy", 32'(busy), 32'd0);

    // ERET: bd/epc/code driven 0, redirect to EPC
    cycle();
    cp0_epc = 32'h8000_ABCC;
    apply(32'h8000_9004, 1'b1, 7'b000_0000, 32'h0, 1'b1);
    expect_evt("eret", 5'd0, 1'b0, 32'h0, 32'h0, 1'b1);
    drain("eret", 32'h8000_ABCC);

    // ERET together with RI: RI wins and fetch goes to the vector
    cycle();
    apply(32'h8000_A000, 1'b0, 7'b000_0010, 32'h0, 1'b1);
    expect_evt("eretri", 5'd10, 1'b0, 32'h8000_A000, 32'h0, 1'b0);
    drain("eretri", 32'h8000_0180);

    // Stall in REDIRECT for 5 cycles with a new Ov commit presented
    cycle();
    cp0_status = BEV1;
    apply(32'h8000_B000, 1'b0, 7'b000_0100, 32'h0, 1'b0);
    expect_evt("hold", 5'd12, 1'b0, 32'h8000_B000, 32'h0, 1'b0);
    cycle();
    idle_inputs();
    cycle();
    for (int i = 0; i < 5; i++) begin
      apply(32'h8000_C000, 1'b0, 7'b000_0100, 32'h0, 1'b0);
      @(negedge clk);
      chk("hold.exc",   32'(exc_valid), 32'd0);
      chk("hold.flush", 32'(flush), 32'd0);
      chk("hold.rv",    32'(redirect_valid), 32'd1);
      chk("hold.pc",    redirect_pc, 32'hBFC0_0380);
      chk("hold.busy",  32'(busy), 32'd1);
      cycle();
    end
    idle_inputs();
    redirect_ready = 1'b1;
    cycle();
    redirect_ready = 1'b0;
    @(negedge clk);
    chk("hold.done_busy", 32'(busy), 32'd0);
    chk("hold.done_rv",   32'(redirect_valid), 32'd0);
    cp0_status = '0;

    // Reset during REDIRECT drops the outstanding redirect
    cycle();
    apply(32'h8000_D000, 1'b0, 7'b000_0100, 32'h0, 1'b0);
    expect_evt("rstrd", 5'd12, 1'b0, 32'h8000_D000, 32'h0, 1'b0);
    cycle();
    idle_inputs();
    cycle();
    @(negedge clk);
    chk("rstrd.pre_rv", 32'(redirect_valid), 32'd1);
    resetn = 1'b0;
    cycle();
    resetn = 1'b1;
    @(negedge clk);
    chk("rstrd.busy",  32'(busy), 32'd0);
    chk("rstrd.rv",    32'(redirect_valid), 32'd0);
    chk("rstrd.flush", 32'(flush), 32'd0);
    chk("rstrd.rpc",   redirect_pc, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/exc_ctrl.md
Name: exc_ctrl

Overview:
Exception/interrupt controller that sequences the CP0 exception interface. Sits at the MEM (commit) stage.
- Selects the highest-priority exception flag carried by the committing instruction, or a pending interrupt, or ERET.
- Drives the CP0 exception-event inputs, flushes the pipeline, then hands the redirect PC to fetch with a valid/ready handshake.
- Blocks further commits until fetch accepts the redirect.

Parameters:
VEC_BEV1, 32'hBFC00380, exception entry when Status.BEV=1
VEC_BEV0, 32'h80000180, exception entry when Status.BEV=0
FLUSH_CYCLES, 1, cycles flush is held after an event (>=1)

Ports:
clk  in  1  clock
resetn  in  1  reset, synchronous, active-low
mem_valid  in  1  instruction in MEM is valid and committing this cycle
mem_pc  in  32  PC of the MEM instruction
mem_bd  in  1  MEM instruction is in a branch delay slot
mem_exc  in  7  flags: [0]AdEL-fetch [1]RI [2]Ov [3]Sys [4]Bp [5]AdEL-data [6]AdES
mem_data_addr  in  32  data virtual address of the MEM load/store
mem_eret  in  1  MEM instruction is ERET
ext_int_response  in  1  CP0 unmasked-interrupt indication
cp0_status  in  32  CP0 Status (bit22 BEV, bit1 EXL)
cp0_epc  in  32  CP0 EPC
exc_valid  out  1  event strobe to CP0
exc_excode  out  5  ExcCode to CP0
exc_bd  out  1  BD to CP0
exc_epc  out  32  EPC value to CP0
exc_badvaddr  out  32  BadVAddr to CP0
exc_eret  out  1  event is ERET
flush  out  1  kill IF..MEM and squash the MEM write-back
redirect_valid  out  1  redirect PC available to fetch
redirect_pc  out  32  new fetch PC
redirect_ready  in  1  fetch accepts the redirect
busy  out  1  state != IDLE; stalls commit

Behaviour:
- State machine: IDLE, FLUSH, REDIRECT. Reset: IDLE; int_pending=0; redirect_valid=0; redirect_pc=0; flush_cnt=0.
- int_pending register:
  - Each cycle int_pending <= ext_int_response.
  - Cleared the cycle after an interrupt is taken, for one cycle.
- Event condition (IDLE only): mem_valid && (int_pending || |mem_exc || mem_eret).
- Event priority: Int(0) > AdEL-fetch(4) > RI(10) > Ov(12) > Sys(8) > Bp(9) > AdEL-data(4) > AdES(5) > ERET.
- CP0 outputs are combinational; they are non-zero only in an IDLE event cycle.
  - exc_valid=1 on any event.
  - exc_excode is per the priority above.
  - exc_bd=mem_bd.
  - exc_epc = mem_bd ? mem_pc-4 : mem_pc, wrapping modulo 2^32.
  - exc_eret=1 only when ERET is the selected event. On ERET, excode/bd/epc are don't-care but driven 0.
- exc_badvaddr = mem_pc for AdEL-fetch; mem_data_addr for AdEL/AdES-data; else 0.
- flush=1 combinationally in the event cycle and throughout FLUSH.
- IDLE -> FLUSH on event. At the same edge:
  - flush_cnt <= FLUSH_CYCLES-1.
  - redirect_pc latched: ERET -> cp0_epc; other events -> cp0_status[22] ? VEC_BEV1 : VEC_BEV0.
- FLUSH: decrement flush_cnt. When it reaches 0, go to REDIRECT and set redirect_valid=1.
- REDIRECT: hold redirect_valid and redirect_pc stable until redirect_ready. On the handshake edge, go to IDLE with redirect_valid=0.
- busy=1 in FLUSH/REDIRECT. mem_valid is ignored there; new events cannot start, but int_pending keeps tracking ext_int_response.
- If Status.EXL=1 when an exception is taken, it is still signalled; CP0 preserves EPC/Cause itself.
- Interrupt and exception flags together: Int wins, and the instruction does not commit (flush squashes it).
- ERET together with any exc flag: the exception wins, exc_eret=0.
- redirect_ready asserted while not in REDIRECT: ignored.
- resetn low in any state: next edge forces IDLE and reset values. Any outstanding redirect is dropped.

Decomposition:
- Shared package holds:
  - EXC_* ExcCode constants: Int 0, AdEL 4, AdES 5, Sys 8, Bp 9, RI 10, Ov 12.
  - mem_exc bit indices.
  - State encoding.
  - Status_BEV/Status_EXL bit positions.
- One natural sub-module: exc_prio_enc (combinational priority encoder: flags + int_pending + eret -> excode, eret_sel, badv_sel).

Test Plan:
- mem_valid=1, mem_pc=0x80001000, mem_exc[2]=1, BEV=0 -> same cycle: exc_valid=1, excode=12, epc=0x80001000, flush=1. redirect_valid rises 2 cycles later with pc 0x80000180. Accepted on the ready cycle, then IDLE.
- AdES with mem_bd=1, mem_pc=0x80002004, data_addr=0x1003 -> excode=5, bd=1, epc=0x80002000, badvaddr=0x1003. BEV=1 -> redirect 0xBFC00380.
- ext_int_response=1 one cycle before commit of a valid instruction that also has mem_exc[3] -> excode=0, not 8. int_pending is 0 for the following cycle.
- mem_eret=1, cp0_epc=0x8000ABCC -> exc_valid=1, exc_eret=1, redirect_pc=0x8000ABCC. ERET plus mem_exc[1] -> excode=10, exc_eret=0.
- Hold redirect_ready=0 for 5 cycles in REDIRECT -> redirect_valid/pc stable and busy=1. A second mem_valid with Ov during this time -> no exc_valid.
- resetn=0 for one cycle during REDIRECT -> next cycle IDLE, redirect_valid=0, flush=0, busy=0.
